// File: rtl/mul_share_sched.sv
// -----------------------------------------------------------------------------
// mul_share_sched
// Round-robin scheduler that shares one pipelined signed 11x16 multiplier
// (24-bit product) among NREQ requesters. Each accepted operation pushes a
// requester-ID tag into a shadow pipeline that is MUL_LAT stages deep, so the
// tag leaves the pipeline in the same cycle as its product leaves the
// multiplier. Results leave through one tagged valid/ready stream. Downstream
// backpressure freezes the multiplier (mul_ce), the tag pipeline, the
// round-robin pointer and the output register together.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   req_valid  per-requester operand valid            [NREQ]
//   req_ready  per-requester accept (one-hot or zero) [NREQ]
//   req_a      flattened signed operand A, 11 bits per requester
//   req_b      flattened signed operand B, 16 bits per requester
//   mul_ce     clock enable to the shared multiplier
//   mul_din0   operand A to the multiplier
//   mul_din1   operand B to the multiplier
//   mul_dout   24-bit product returned by the multiplier
//   res_valid  result valid
//   res_ready  downstream accept
//   res_data   24-bit signed product
//   res_id     requester index that produced res_data
//
// Optional build macro MUL_SHARE_SCHED_STATS_EN adds two saturating 32-bit
// counters: stat_issued (accepted operations) and stat_stall (cycles in which
// the pipeline was frozen).
// -----------------------------------------------------------------------------
module mul_share_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int MUL_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*11-1:0]   req_a,
    input  logic [NREQ*16-1:0]   req_b,
    output logic                 mul_ce,
    output logic [10:0]          mul_din0,
    output logic [15:0]          mul_din1,
    input  logic [23:0]          mul_dout,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [23:0]          res_data,
    output logic [IDW-1:0]       res_id
`ifdef MUL_SHARE_SCHED_STATS_EN
    ,
    output logic [31:0]          stat_issued,
    output logic [31:0]          stat_stall
`endif
);

    logic                         adv_s;
    logic                         grant_vld_s;
    logic [IDW-1:0]               grant_idx_s;
    logic [IDW-1:0]               cand_s;
    logic [IDW-1:0]               sel_s;
    logic                         xfer_s;

    logic [IDW-1:0]               last_q, last_d;
    logic [MUL_LAT-1:0]           tag_vld_q, tag_vld_d;
    logic [MUL_LAT-1:0][IDW-1:0]  tag_id_q, tag_id_d;
    logic                         res_valid_q, res_valid_d;
    logic [23:0]                  res_data_q, res_data_d;
    logic [IDW-1:0]               res_id_q, res_id_d;

    // Pipeline advances whenever the output register is empty or being drained.
    assign adv_s  = ~res_valid_q | res_ready;
    assign mul_ce = adv_s;
    assign xfer_s = adv_s & grant_vld_s;

    // Round-robin search: first valid requester after the last granted one.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = last_q;
        cand_s      = last_q;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = IDW'((int'(last_q) + k) % NREQ);
            if (!grant_vld_s && req_valid[cand_s]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // One-hot accept, suppressed while the pipeline is frozen.
    always_comb begin
        req_ready = '0;
        if (adv_s && grant_vld_s) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Operand mux; with no grant the last winner's operands are presented,
    // which is harmless because no valid tag accompanies them.
    always_comb begin
        sel_s    = grant_vld_s ? grant_idx_s : last_q;
        mul_din0 = req_a[10:0];
        mul_din1 = req_b[15:0];
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == sel_s) begin
                mul_din0 = req_a[11*i +: 11];
                mul_din1 = req_b[16*i +: 16];
            end else begin
                mul_din0 = mul_din0;
            end
        end
    end

    // Next-state for pointer, tag shadow pipeline and output register.
    always_comb begin
        last_d      = last_q;
        tag_vld_d   = tag_vld_q;
        tag_id_d    = tag_id_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        if (xfer_s) begin
            last_d = grant_idx_s;
        end else begin
            last_d = last_q;
        end
        if (adv_s) begin
            tag_vld_d[0] = xfer_s;
            tag_id_d[0]  = grant_idx_s;
            for (int s = 1; s < MUL_LAT; s++) begin
                tag_vld_d[s] = tag_vld_q[s-1];
                tag_id_d[s]  = tag_id_q[s-1];
            end
            // Last tag stage lines up with the product on mul_dout.
            res_valid_d = tag_vld_q[MUL_LAT-1];
            if (tag_vld_q[MUL_LAT-1]) begin
                res_data_d = mul_dout;
                res_id_d   = tag_id_q[MUL_LAT-1];
            end else begin
                res_data_d = res_data_q;
            end
        end else begin
            res_valid_d = res_valid_q;
        end
    end

    // State registers; in-flight products are dropped by clearing tag valids.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q      <= IDW'(NREQ - 1);
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= 24'd0;
            res_id_q    <= '0;
        end else begin
            last_q      <= last_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

`ifdef MUL_SHARE_SCHED_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

    // Saturating event counters.
    always_comb begin
        stat_issued_d = stat_issued_q;
        stat_stall_d  = stat_stall_q;
        if (xfer_s) begin
            stat_issued_d = sat_inc(stat_issued_q);
        end else begin
            stat_issued_d = stat_issued_q;
        end
        if (!adv_s) begin
            stat_stall_d = sat_inc(stat_stall_q);
        end else begin
            stat_stall_d = stat_stall_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_issued_q <= 32'd0;
            stat_stall_q  <= 32'd0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule
